filter_line_ctrl_5x5: RTL and testbench
=======================================

Name: filter_line_ctrl_5x5

Overview:
- Line-buffer controller placed directly upstream of the 5x5 data-align stage.
- Tracks pixel and line position from the incoming video DE stream.
- Generates the line-memory write/read addresses, the ring line select and the read enable that the align stage consumes.
- Generates the top/bottom line-padding flags, and produces the 2 flush lines after the last input line so the bottom rows of the frame are emitted.

Parameters:
MEM_ADDR_WIDTH, 11, line-memory address width; max line width 2^MEM_ADDR_WIDTH
V_CNT_WIDTH, 11, line counter width
FLUSH_HBLANK, 16, idle cycles before each internally generated flush line (>=4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_vsync  in  1  one-cycle frame-start pulse, only while i_de=0
i_de  in  1  input pixel valid; one contiguous burst per line
i_h_last  in  MEM_ADDR_WIDTH  line width minus 1; sampled at i_vsync
i_v_size  in  V_CNT_WIDTH  lines per frame (>=5); sampled at i_vsync
o_mem_ren  out  1  line-memory read enable (align stage i_mem_ren)
o_mem_sel  out  2  ring index of the line being written (i_mem_sel)
o_mem_waddr  out  MEM_ADDR_WIDTH  write address, aligned to the stage's 1-cycle-delayed DE
o_mem_raddr  out  MEM_ADDR_WIDTH  read address
o_pad_y  out  4  one-hot line-padding flags (i_pad_y)
o_busy  out  1  frame in progress (FILL..FLUSH)
o_frame_done  out  1  one-cycle pulse when the last output line's reads finish
o_err  out  1  sticky: i_vsync seen while o_busy, or i_de burst length != i_h_last+1

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; counters 0; o_err cleared.
- FSM states: IDLE, FILL, RUN, FLUSH_GAP, FLUSH_LINE.
  - IDLE/any state --i_vsync--> FILL. Latches sizes; line_idx=0, px=0, o_mem_sel=0.
- Pixel counter px:
  - Increments on every i_de cycle (or internal flush DE).
  - Cleared on the cycle after DE falls.
  - o_mem_raddr = px, combinational and co-timed with i_de.
  - o_mem_waddr = px registered 1 cycle, matching the stage's r_de write timing.
  - Memory read-before-write of the same address on the next cycle is intended.
- Line end: the 2nd cycle after DE falls (after the delayed write completes).
  - line_idx += 1 and o_mem_sel += 1 (mod 4 wrap 3->0).
  - o_pad_y is updated for the next line.
  - Required hblank is >=3 cycles; a shorter gap sets o_err and behaviour is undefined.
- FILL (line_idx 0,1): writes only, o_mem_ren=0. Go to RUN at the end of line 1.
- RUN (line_idx 2..V-1):
  - o_mem_ren = i_de, combinational, same cycle.
  - The centre row output is c = line_idx-2.
  - At the end of line V-1, go to FLUSH_GAP.
- FLUSH_GAP: count FLUSH_HBLANK idle cycles, then go to FLUSH_LINE.
- FLUSH_LINE: internal DE runs for i_h_last+1 cycles.
  - o_mem_ren = internal DE. No writes, because i_de is low.
  - o_mem_sel keeps advancing (lines V, V+1).
  - After the flush for c=V-2, go to FLUSH_GAP again. After c=V-1, pulse o_frame_done and go to IDLE.
- o_pad_y is constant over a line, indexed by centre row c:
  - c=0 -> 4'b0001
  - c=1 -> 4'b0010
  - c=V-2 -> 4'b1000
  - c=V-1 -> 4'b0100
  - otherwise 4'b0000
  - It is 0 in FILL and IDLE.
- i_de in IDLE: ignored; no address or ren activity.
- i_de during FLUSH: sets o_err, and the input is ignored.
- i_vsync while o_busy: sets o_err, aborts the current frame and restarts FILL. No o_frame_done for the aborted frame.
- Burst length mismatch: sets o_err. px never exceeds i_h_last; extra pixels are not written (waddr saturates and write is suppressed by holding ren/addr at i_h_last).
- rst mid-frame: returns to IDLE next cycle; no o_frame_done.

Decomposition:
- Package filter_pkg holds:
  - the state encoding constants (IDLE..FLUSH_LINE);
  - the pad one-hot constants PAD_TOP0 / PAD_TOP1 / PAD_BOT1 / PAD_BOT0;
  - MIN_HBLANK=3.
- One sub-module, filter_line_timer: the px counter plus DE-fall detector and line-end strobe. It is used for both the input-driven and the internal flush timing.

Test Plan:
- rst held 3 cycles mid-RUN -> next cycle all outputs 0, state IDLE, o_frame_done never pulses.
- vsync, i_h_last=7, i_v_size=6, 6 lines of 8 DE with hblank 10 -> expected response:
  - o_mem_ren low for lines 0-1;
  - o_mem_sel sequence 0,1,2,3,0,1 then 2,3 during flush;
  - 4 lines in RUN plus 2 flush lines, each 8 ren cycles;
  - o_frame_done pulses once, 2 cycles after the last flush ren.
- Within a RUN line -> raddr 0..7 co-timed with i_de, waddr 0..7 one cycle later.
- o_pad_y per output line -> 0001, 0010, 0000, 0000, 1000, 0100.
- Second vsync issued during line 3 -> o_err=1, o_mem_sel returns to 0, FILL restarts, no o_frame_done.
- A 9-pixel burst with i_h_last=7 -> o_err=1; raddr/waddr never exceed 7.
- i_de pulses in IDLE with no vsync -> o_mem_ren stays 0, o_busy stays 0.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared state encoding, padding constants and helpers for the 5x5 filter
// line-buffer controller.
package filter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL       = 3'd1,
    RUN        = 3'd2,
    FLUSH_GAP  = 3'd3,
    FLUSH_LINE = 3'd4
  } state_t;

  // One-hot row-padding flags consumed by the align stage.
  localparam logic [3:0] PAD_TOP0 = 4'b0001;  // centre row 0
  localparam logic [3:0] PAD_TOP1 = 4'b0010;  // centre row 1
  localparam logic [3:0] PAD_BOT1 = 4'b1000;  // centre row V-2
  localparam logic [3:0] PAD_BOT0 = 4'b0100;  // centre row V-1

  localparam int MIN_HBLANK = 3;

  function automatic logic [3:0] pad_for_row(input int unsigned c, input int unsigned v);
    logic [3:0] flags;
    flags = 4'b0000;
    if (c == 0) begin
      flags = PAD_TOP0;
    end else if (c == 1) begin
      flags = PAD_TOP1;
    end else if (c == v - 2) begin
      flags = PAD_BOT1;
    end else if (c == v - 1) begin
      flags = PAD_BOT0;
    end
    return flags;
  endfunction

endpackage

// File: rtl/filter_line_ctrl_5x5_if.sv
// Line-memory control bus between the line-buffer controller (master) and
// the 5x5 data-align stage (slave).
interface filter_line_ctrl_5x5_if #(
  parameter int MEM_ADDR_WIDTH = 11
);

  logic                      mem_ren;
  logic [1:0]                mem_sel;
  logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
  logic [MEM_ADDR_WIDTH-1:0] mem_raddr;
  logic [3:0]                pad_y;

  modport master (
    output mem_ren,
    output mem_sel,
    output mem_waddr,
    output mem_raddr,
    output pad_y
  );

  modport slave (
    input mem_ren,
    input mem_sel,
    input mem_waddr,
    input mem_raddr,
    input pad_y
  );

endinterface

// File: rtl/filter_line_timer.sv
// Pixel counter with DE-fall detection and a line-end strobe two cycles after
// the last pixel; also flags burst-length and short-hblank violations.
module filter_line_timer
  import filter_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          de,
  input  logic [AW-1:0] h_last,
  output logic [AW-1:0] px,
  output logic [AW-1:0] waddr,
  output logic          line_end,
  output logic          len_err,
  output logic          gap_err
);

  localparam int BW = $clog2(MIN_HBLANK + 1);

  logic [AW-1:0] px_reg, px_next;
  logic [AW-1:0] waddr_reg;
  logic          de_d1_reg;
  logic          fall_reg;
  logic          full_reg, full_next;
  logic [BW-1:0] blank_reg, blank_next;
  logic          fall;

  assign fall     = de_d1_reg & ~de;
  assign px       = px_reg;
  assign waddr    = waddr_reg;
  assign line_end = fall_reg;

  always_comb begin
    px_next    = px_reg;
    full_next  = full_reg;
    blank_next = blank_reg;
    len_err    = 1'b0;
    gap_err    = 1'b0;

    if (de) begin
      // Saturate at the last pixel so an overlong burst keeps hitting h_last.
      if (px_reg != h_last) begin
        px_next = px_reg + AW'(1);
      end else begin
        if (full_reg) begin
          len_err = 1'b1;
        end
        full_next = 1'b1;
      end
      if (!de_d1_reg && (blank_reg < BW'(MIN_HBLANK))) begin
        gap_err = 1'b1;
      end
      blank_next = '0;
    end else begin
      if (fall) begin
        px_next   = '0;
        full_next = 1'b0;
        if (!full_reg) begin
          len_err = 1'b1;
        end
      end
      if (blank_reg < BW'(MIN_HBLANK)) begin
        blank_next = blank_reg + BW'(1);
      end
    end

    // A frame restart discards any partial line; the first line owes no hblank.
    if (clr) begin
      px_next    = '0;
      full_next  = 1'b0;
      blank_next = BW'(MIN_HBLANK);
      len_err    = 1'b0;
      gap_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_reg    <= '0;
      waddr_reg <= '0;
      de_d1_reg <= 1'b0;
      fall_reg  <= 1'b0;
      full_reg  <= 1'b0;
      blank_reg <= '0;
    end else begin
      px_reg    <= px_next;
      waddr_reg <= px_reg;
      de_d1_reg <= clr ? 1'b0 : de;
      fall_reg  <= clr ? 1'b0 : fall;
      full_reg  <= full_next;
      blank_reg <= blank_next;
    end
  end

endmodule

// File: rtl/filter_line_ctrl_5x5.sv
// Line-buffer controller ahead of the 5x5 align stage: ring addressing, read
// enable, row padding and the two trailing flush lines that drain the frame.
module filter_line_ctrl_5x5
  import filter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int V_CNT_WIDTH    = 11,
  parameter int FLUSH_HBLANK   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_vsync,
  input  logic                      i_de,
  input  logic [MEM_ADDR_WIDTH-1:0] i_h_last,
  input  logic [V_CNT_WIDTH-1:0]    i_v_size,
  filter_line_ctrl_5x5_if.master    mem,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_err
);

  localparam int LW = V_CNT_WIDTH + 1;
  localparam int GW = $clog2(FLUSH_HBLANK) + 1;

  state_t                    state_reg, state_next;
  logic [LW-1:0]             line_idx_reg, line_idx_next;
  logic [1:0]                sel_reg, sel_next;
  logic [MEM_ADDR_WIDTH-1:0] h_last_reg, h_last_next;
  logic [V_CNT_WIDTH-1:0]    v_size_reg, v_size_next;
  logic [GW-1:0]             gap_cnt_reg, gap_cnt_next;
  logic                      flush_run_reg, flush_run_next;
  logic                      err_reg, err_next;
  logic                      frame_done;

  logic                      in_state;
  logic                      flush_state;
  logic                      eff_de;
  logic [MEM_ADDR_WIDTH-1:0] px;
  logic [MEM_ADDR_WIDTH-1:0] waddr;
  logic                      line_end;
  logic                      len_err;
  logic                      gap_err;
  logic [LW-1:0]             v_ext;
  logic [LW-1:0]             centre;

  assign in_state    = (state_reg == FILL) || (state_reg == RUN);
  assign flush_state = (state_reg == FLUSH_GAP) || (state_reg == FLUSH_LINE);
  // Input DE drives the timer while lines arrive; the flush DE takes over after.
  assign eff_de      = in_state ? i_de : flush_run_reg;
  assign v_ext       = {1'b0, v_size_reg};
  assign centre      = line_idx_reg - LW'(2);

  filter_line_timer #(
    .AW(MEM_ADDR_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (i_vsync),
    .de       (eff_de),
    .h_last   (h_last_reg),
    .px       (px),
    .waddr    (waddr),
    .line_end (line_end),
    .len_err  (len_err),
    .gap_err  (gap_err)
  );

  always_comb begin
    state_next     = state_reg;
    line_idx_next  = line_idx_reg;
    sel_next       = sel_reg;
    h_last_next    = h_last_reg;
    v_size_next    = v_size_reg;
    gap_cnt_next   = gap_cnt_reg;
    flush_run_next = flush_run_reg;
    err_next       = err_reg;
    frame_done     = 1'b0;

    if (len_err || gap_err || (flush_state && i_de)) begin
      err_next = 1'b1;
    end
    if (flush_run_reg && (px == h_last_reg)) begin
      flush_run_next = 1'b0;
    end

    if (i_vsync) begin
      if (state_reg != IDLE) begin
        err_next = 1'b1;
      end
      state_next     = FILL;
      line_idx_next  = '0;
      sel_next       = 2'd0;
      h_last_next    = i_h_last;
      v_size_next    = i_v_size;
      gap_cnt_next   = '0;
      flush_run_next = 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (line_end) begin
            line_idx_next = line_idx_reg + LW'(1);
            sel_next      = sel_reg + 2'd1;
            if (line_idx_reg == LW'(1)) begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (line_end) begin
            line_idx_next = line_idx_reg + LW'(1);
            sel_next      = sel_reg + 2'd1;
            gap_cnt_next  = '0;
            if (line_idx_reg == v_ext - LW'(1)) begin
              state_next = FLUSH_GAP;
            end
          end
        end
        FLUSH_GAP: begin
          if (gap_cnt_reg == GW'(FLUSH_HBLANK - 1)) begin
            state_next     = FLUSH_LINE;
            flush_run_next = 1'b1;
            gap_cnt_next   = '0;
          end else begin
            gap_cnt_next = gap_cnt_reg + GW'(1);
          end
        end
        FLUSH_LINE: begin
          if (line_end) begin
            line_idx_next = line_idx_reg + LW'(1);
            sel_next      = sel_reg + 2'd1;
            gap_cnt_next  = '0;
            if (line_idx_reg == v_ext + LW'(1)) begin
              frame_done = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = FLUSH_GAP;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      line_idx_reg  <= '0;
      sel_reg       <= 2'd0;
      h_last_reg    <= '0;
      v_size_reg    <= '0;
      gap_cnt_reg   <= '0;
      flush_run_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      line_idx_reg  <= line_idx_next;
      sel_reg       <= sel_next;
      h_last_reg    <= h_last_next;
      v_size_reg    <= v_size_next;
      gap_cnt_reg   <= gap_cnt_next;
      flush_run_reg <= flush_run_next;
      err_reg       <= err_next;
    end
  end

  assign mem.mem_ren   = ((state_reg == RUN) || (state_reg == FLUSH_LINE)) && eff_de;
  assign mem.mem_sel   = sel_reg;
  assign mem.mem_raddr = px;
  assign mem.mem_waddr = waddr;
  assign mem.pad_y     = ((state_reg == RUN) || flush_state)
                         ? pad_for_row(32'(centre), 32'(v_size_reg)) : 4'b0000;

  assign o_busy       = (state_reg != IDLE);
  assign o_frame_done = frame_done;
  assign o_err        = err_reg;

endmodule

// File: tb/tb_filter_line_ctrl_5x5.sv
// Directed bench for the 5x5 line-buffer controller: one frame end to end,
// abort, mid-frame reset, overlong burst and DE activity while idle.
module tb_filter_line_ctrl_5x5;

  localparam int AW = 11;
  localparam int VW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vsync;
  logic          i_de;
  logic [AW-1:0] i_h_last;
  logic [VW-1:0] i_v_size;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_ren_cyc = 0;
  int burst_len = 0;
  int max_raddr = 0;
  int max_waddr = 0;
  bit prev_ren = 1'b0;
  int sel_q[$];
  int pad_q[$];
  int len_q[$];

  filter_line_ctrl_5x5_if #(.MEM_ADDR_WIDTH(AW)) mem_bus ();

  filter_line_ctrl_5x5 #(
    .MEM_ADDR_WIDTH(AW),
    .V_CNT_WIDTH   (VW),
    .FLUSH_HBLANK  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_vsync     (i_vsync),
    .i_de        (i_de),
    .i_h_last    (i_h_last),
    .i_v_size    (i_v_size),
    .mem         (mem_bus.master),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    sel_q.delete();
    pad_q.delete();
    len_q.delete();
    done_cnt  = 0;
    max_raddr = 0;
    max_waddr = 0;
  endtask

  task automatic start_frame(input int h_last, input int v_size);
    i_h_last = AW'(h_last);
    i_v_size = VW'(v_size);
    i_vsync  = 1'b1;
    tick();
    i_vsync  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int n, input int gap, input bit chk,
                           output int ren_cnt, output int first_sel);
    ren_cnt   = 0;
    first_sel = -1;
    for (int i = 0; i < n; i++) begin
      i_de = 1'b1;
      @(negedge clk);
      if (i == 0) first_sel = int'(mem_bus.mem_sel);
      if (mem_bus.mem_ren) ren_cnt++;
      if (chk) begin
        check_val($sformatf("raddr[%0d]", i), int'(mem_bus.mem_raddr), i);
        if (i > 0) check_val($sformatf("waddr[%0d]", i - 1), int'(mem_bus.mem_waddr), i - 1);
      end
      tick();
    end
    i_de = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (chk && i == 0) check_val($sformatf("waddr[%0d]", n - 1), int'(mem_bus.mem_waddr), n - 1);
      tick();
    end
  endtask

  // Passive observer: records each ren burst and frame_done timing.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_bus.mem_ren) begin
        if (!prev_ren) begin
          sel_q.push_back(int'(mem_bus.mem_sel));
          pad_q.push_back(int'(mem_bus.pad_y));
          burst_len = 0;
        end
        burst_len++;
        last_ren_cyc = cyc;
      end else if (prev_ren) begin
        len_q.push_back(burst_len);
      end
      prev_ren = mem_bus.mem_ren;
      if (o_frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (int'(mem_bus.mem_raddr) > max_raddr) max_raddr = int'(mem_bus.mem_raddr);
      if (int'(mem_bus.mem_waddr) > max_waddr) max_waddr = int'(mem_bus.mem_waddr);
    end
  end

  initial begin
    int rc;
    int sl;
    int exp_sel[6] = '{2, 3, 0, 1, 2, 3};
    int exp_pad[6] = '{1, 2, 0, 0, 8, 4};
    int got;
    bit ren_any;
    bit busy_any;

    rst = 1'b1; i_vsync = 1'b0; i_de = 1'b0; i_h_last = '0; i_v_size = '0;
    repeat (3) tick();
    @(negedge clk);
    check_val("rst_ren", int'(mem_bus.mem_ren), 0);
    check_val("rst_busy", int'(o_busy), 0);
    check_val("rst_err", int'(o_err), 0);
    tick();
    rst = 1'b0;

    // DE while idle must be ignored.
    ren_any = 1'b0; busy_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_de = 1'b1;
      @(negedge clk);
      ren_any  = ren_any | mem_bus.mem_ren;
      busy_any = busy_any | o_busy;
      tick();
    end
    i_de = 1'b0;
    repeat (4) tick();
    check_val("idle_ren", int'(ren_any), 0);
    check_val("idle_busy", int'(busy_any), 0);

    // Complete frame: 8 pixels x 6 lines.
    clear_rec();
    start_frame(7, 6);
    for (int ln = 0; ln < 6; ln++) begin
      send_line(8, 10, ln == 2, rc, sl);
      check_val($sformatf("line%0d_ren", ln), rc, (ln < 2) ? 0 : 8);
      check_val($sformatf("line%0d_sel", ln), sl, ln % 4);
    end
    for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
    repeat (20) tick();
    check_val("bursts", sel_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      got = (k < sel_q.size()) ? sel_q[k] : -1;
      check_val($sformatf("burst%0d_sel", k), got, exp_sel[k]);
      got = (k < pad_q.size()) ? pad_q[k] : -1;
      check_val($sformatf("burst%0d_pad", k), got, exp_pad[k]);
      got = (k < len_q.size()) ? len_q[k] : -1;
      check_val($sformatf("burst%0d_len", k), got, 8);
    end
    check_val("done_cnt", done_cnt, 1);
    check_val("done_lag", done_cyc - last_ren_cyc, 2);
    check_val("frame_busy", int'(o_busy), 0);
    check_val("frame_err", int'(o_err), 0);

    // Second vsync during line 3 aborts the frame.
    clear_rec();
    start_frame(7, 6);
    for (int ln = 0; ln < 3; ln++) send_line(8, 10, 1'b0, rc, sl);
    send_line(8, 0, 1'b0, rc, sl);
    i_vsync = 1'b1;
    @(negedge clk);
    check_val("abort_err_before", int'(o_err), 0);
    tick();
    i_vsync = 1'b0;
    @(negedge clk);
    check_val("abort_err", int'(o_err), 1);
    check_val("abort_sel", int'(mem_bus.mem_sel), 0);
    check_val("abort_busy", int'(o_busy), 1);
    tick();
    repeat (2) tick();
    send_line(8, 10, 1'b0, rc, sl);
    check_val("abort_fill_ren", rc, 0);
    check_val("abort_fill_sel", sl, 0);
    repeat (60) tick();
    check_val("abort_done", done_cnt, 0);

    // Reset held for three cycles in the middle of a RUN line.
    clear_rec();
    start_frame(7, 6);
    for (int ln = 0; ln < 2; ln++) send_line(8, 10, 1'b0, rc, sl);
    i_de = 1'b1;
    tick();
    @(negedge clk);
    check_val("mid_run_ren", int'(mem_bus.mem_ren), 1);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    i_de = 1'b0;
    @(negedge clk);
    check_val("mrst_ren", int'(mem_bus.mem_ren), 0);
    check_val("mrst_sel", int'(mem_bus.mem_sel), 0);
    check_val("mrst_raddr", int'(mem_bus.mem_raddr), 0);
    check_val("mrst_waddr", int'(mem_bus.mem_waddr), 0);
    check_val("mrst_pad", int'(mem_bus.pad_y), 0);
    check_val("mrst_busy", int'(o_busy), 0);
    check_val("mrst_err", int'(o_err), 0);
    tick();
    repeat (50) tick();
    check_val("mrst_done", done_cnt, 0);

    // Overlong burst: 9 pixels against a width of 8.
    start_frame(7, 6);
    check_val("long_err_before", int'(o_err), 0);
    clear_rec();
    send_line(9, 10, 1'b0, rc, sl);
    check_val("long_err", int'(o_err), 1);
    check_val("long_max_raddr", max_raddr, 7);
    check_val("long_max_waddr", max_waddr, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
